// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS-subset control FSM (FETCH/DECODE/EXE/MEM/WB)
// with a parameterised number of memory stall cycles.
module mc_ctrl #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWr,
  output logic       IRWr,
  output logic [1:0] PC_sel,
  output logic [1:0] RegDst,
  output logic [1:0] Data_to_Reg_sel,
  output logic       ALUSrc,
  output logic       ExtOp,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic [4:0] ALUCtr,
  output logic [2:0] state,
  output logic       done
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXE = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;
  state_t r_state, w_next;
  logic [3:0] r_wait;
  logic w_rtype, w_addu, w_subu, w_jr, w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal, w_exe, w_last;
  assign w_rtype = op == 6'h00;
  assign w_addu  = w_rtype && funct == 6'h21;
  assign w_subu  = w_rtype && funct == 6'h23;
  assign w_jr    = w_rtype && funct == 6'h08;
  assign w_ori   = op == 6'h0D;
  assign w_lui   = op == 6'h0F;
  assign w_lw    = op == 6'h23;
  assign w_sw    = op == 6'h2B;
  assign w_beq   = op == 6'h04;
  assign w_j     = op == 6'h02;
  assign w_jal   = op == 6'h03;
  assign w_exe   = w_addu | w_subu | w_ori | w_lui | w_lw | w_sw | w_beq;
  assign w_last  = r_wait == 4'(MEM_WAIT);
  assign state   = r_state;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= FETCH;
      r_wait  <= 4'd0;
    end else begin
      r_state <= w_next;
      r_wait  <= (r_state == MEM) ? r_wait + 4'd1 : 4'd0;
    end
  // Selects are decoded from the held opcode so they stay stable for the whole instruction;
  // every enable is additionally gated by reset so it drops without waiting for a clock.
  always_comb begin
    w_next          = FETCH;
    PCWr            = 1'b0;
    IRWr            = 1'b0;
    PC_sel          = 2'b00;
    RegWrite        = 1'b0;
    MemRead         = 1'b0;
    MemWrite        = 1'b0;
    done            = 1'b0;
    RegDst          = w_rtype ? 2'b01 : 2'b00;
    Data_to_Reg_sel = w_lw ? 2'b01 : 2'b00;
    ALUSrc          = w_lw | w_sw | w_ori | w_lui;
    ExtOp           = w_lw | w_sw;
    ALUCtr          = (w_subu | w_beq) ? 5'd1 : w_ori ? 5'd2 : w_lui ? 5'd3 : 5'd0;
    if (!reset)
      case (r_state)
        FETCH: begin
          IRWr   = 1'b1;
          PCWr   = 1'b1;
          w_next = DECODE;
        end
        DECODE: begin
          PCWr   = w_j | w_jal | w_jr;
          PC_sel = w_jr ? 2'b11 : (w_j | w_jal) ? 2'b10 : 2'b00;
          if (w_jal) begin
            RegWrite        = 1'b1;
            RegDst          = 2'b10;
            Data_to_Reg_sel = 2'b10;
          end
          done   = !w_exe;
          w_next = w_exe ? EXE : FETCH;
        end
        EXE: begin
          PCWr   = w_beq & zero;
          PC_sel = w_beq ? 2'b01 : 2'b00;
          done   = w_beq;
          w_next = w_beq ? FETCH : (w_lw | w_sw) ? MEM : WB;
        end
        MEM: begin
          MemRead  = w_lw;
          MemWrite = w_sw & w_last;
          done     = w_sw & w_last;
          w_next   = !w_last ? MEM : w_lw ? WB : FETCH;
        end
        WB: begin
          RegWrite = 1'b1;
          done     = 1'b1;
        end
        default: w_next = FETCH;
      endcase
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench for mc_ctrl; one instance with MEM_WAIT=0, one with MEM_WAIT=3,
// each exercised in turn while the other is held in reset.
module tb_mc_ctrl;
  typedef struct packed {
    logic [2:0] st;
    logic       pcwr, irwr;
    logic [1:0] pcsel;
    logic       rw, mr, mw, dn;
    logic [1:0] rdst, d2r;
    logic       aso, eo;
    logic [4:0] ac;
  } vec_t;
  typedef struct packed {
    logic d;
    logic cdst, calu;
    vec_t v;
  } exp_t;
  typedef enum {K_DEC, K_BEQ, K_ALU, K_LW, K_SW} kind_t;

  logic clk;
  logic rs[2], zi[2];
  logic [5:0] opi[2], fni[2];
  logic pcwr[2], irwr[2], aso[2], eo[2], rw[2], mr[2], mw[2], dn[2];
  logic [1:0] pcsel[2], rdst[2], d2r[2];
  logic [4:0] ac[2];
  logic [2:0] st[2];
  exp_t q[$];
  int checks = 0, errors = 0;
  int wcnt[2] = '{0, 0};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mc_ctrl #(.MEM_WAIT(g * 3)) u_dut (
      .clk(clk), .reset(rs[g]), .op(opi[g]), .funct(fni[g]), .zero(zi[g]),
      .PCWr(pcwr[g]), .IRWr(irwr[g]), .PC_sel(pcsel[g]), .RegDst(rdst[g]),
      .Data_to_Reg_sel(d2r[g]), .ALUSrc(aso[g]), .ExtOp(eo[g]), .RegWrite(rw[g]),
      .MemRead(mr[g]), .MemWrite(mw[g]), .ALUCtr(ac[g]), .state(st[g]), .done(dn[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (q.size() > 0) begin : mon
      exp_t e;
      vec_t a, m;
      e = q.pop_front();
      a = {st[e.d], pcwr[e.d], irwr[e.d], pcsel[e.d], rw[e.d], mr[e.d], mw[e.d], dn[e.d],
           rdst[e.d], d2r[e.d], aso[e.d], eo[e.d], ac[e.d]};
      m = '1;
      if (!e.cdst) begin
        m.rdst = 2'b00;
        m.d2r  = 2'b00;
      end
      if (!e.calu) begin
        m.aso = 1'b0;
        m.eo  = 1'b0;
        m.ac  = 5'd0;
      end
      if (a.mw) wcnt[e.d]++;
      checks++;
      if ((a & m) !== (e.v & m)) begin
        errors++;
        $display("FAIL cycle dut%0d state%0d got %h want %h (mask %h)", e.d, e.v.st, a, e.v, m);
      end
    end

  task automatic check(input string nm, input logic [15:0] a, input logic [15:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, a, x);
    end
  endtask

  task automatic push(input logic d, input exp_t e);
    e.d = d;
    q.push_back(e);
  endtask

  // Caller is positioned in a FETCH cycle before its sampling edge; returns in the next FETCH.
  task automatic issue(input logic d, input logic [5:0] o, input logic [5:0] f, input logic z,
                       input kind_t k, input int n, input logic dpw, input logic [1:0] dps,
                       input logic jal, input logic [1:0] rd, input logic [1:0] dr,
                       input logic sa, input logic se, input logic [4:0] sc);
    exp_t e, s;
    int mc;
    opi[d] = o;
    fni[d] = f;
    zi[d]  = z;
    e = '0;
    e.v.pcwr = 1'b1;
    e.v.irwr = 1'b1;
    push(d, e);
    e = '0;
    e.v.st = 3'd1;
    if (k == K_DEC) begin
      e.v.pcwr  = dpw;
      e.v.pcsel = dps;
      e.v.dn    = 1'b1;
      if (jal) begin
        e.v.rw   = 1'b1;
        e.v.rdst = 2'b10;
        e.v.d2r  = 2'b10;
        e.cdst   = 1'b1;
      end
    end
    push(d, e);
    if (k != K_DEC) begin
      s = '0;
      s.cdst = 1'b1;
      s.calu = 1'b1;
      s.v.rdst = rd;
      s.v.d2r  = dr;
      s.v.aso  = sa;
      s.v.eo   = se;
      s.v.ac   = sc;
      e = s;
      e.v.st = 3'd2;
      if (k == K_BEQ) begin
        e.v.pcwr  = z;
        e.v.pcsel = 2'b01;
        e.v.dn    = 1'b1;
      end
      push(d, e);
      mc = (k == K_LW) ? n - 4 : (k == K_SW) ? n - 3 : 0;
      for (int i = 0; i < mc; i++) begin
        e = s;
        e.v.st = 3'd3;
        e.v.mr = k == K_LW;
        e.v.mw = k == K_SW && i == mc - 1;
        e.v.dn = e.v.mw;
        push(d, e);
      end
      if (k == K_ALU || k == K_LW) begin
        e = s;
        e.v.st = 3'd4;
        e.v.rw = 1'b1;
        e.v.dn = 1'b1;
        push(d, e);
      end
    end
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    exp_t e;
    rs[0] = 1'b1; rs[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      opi[i] = 6'h3F; fni[i] = 6'h00; zi[i] = 1'b0;
    end
    #3;
    check("reset_outputs_d0", 16'({st[0], pcwr[0], irwr[0], rw[0], mr[0], mw[0], dn[0]}), 16'h0);
    @(posedge clk);
    #2;
    rs[0] = 1'b0;
    //     d  op     funct  z     kind   n  dpw   dps    jal   rdst   d2r    asrc  ext   aluctr
    issue(0, 6'h23, 6'h00, 1'b0, K_LW,  5, 1'b0, 2'b00, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 5'd0);
    issue(0, 6'h00, 6'h21, 1'b0, K_ALU, 4, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 5'd0);
    issue(0, 6'h00, 6'h23, 1'b0, K_ALU, 4, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 5'd1);
    issue(0, 6'h0D, 6'h00, 1'b0, K_ALU, 4, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 5'd2);
    issue(0, 6'h0F, 6'h00, 1'b0, K_ALU, 4, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 5'd3);
    issue(0, 6'h04, 6'h00, 1'b1, K_BEQ, 3, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd1);
    issue(0, 6'h04, 6'h00, 1'b0, K_BEQ, 3, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd1);
    issue(0, 6'h2B, 6'h00, 1'b0, K_SW,  4, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 5'd0);
    issue(0, 6'h02, 6'h00, 1'b0, K_DEC, 2, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0);
    issue(0, 6'h03, 6'h00, 1'b0, K_DEC, 2, 1'b1, 2'b10, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0);
    issue(0, 6'h00, 6'h08, 1'b0, K_DEC, 2, 1'b1, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0);
    issue(0, 6'h3F, 6'h00, 1'b0, K_DEC, 2, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0);
    issue(0, 6'h00, 6'h3F, 1'b0, K_DEC, 2, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0);
    rs[0] = 1'b1;
    rs[1] = 1'b0;
    issue(1, 6'h2B, 6'h00, 1'b0, K_SW,  7, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 5'd0);
    issue(1, 6'h23, 6'h00, 1'b0, K_LW,  8, 1'b0, 2'b00, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 5'd0);
    // sw interrupted by reset in its second MEM cycle: no write may ever appear
    opi[1] = 6'h2B;
    fni[1] = 6'h00;
    e = '0;
    e.v.pcwr = 1'b1;
    e.v.irwr = 1'b1;
    push(1, e);
    e = '0;
    e.v.st = 3'd1;
    push(1, e);
    e = '0;
    e.cdst = 1'b1;
    e.calu = 1'b1;
    e.v.aso = 1'b1;
    e.v.eo  = 1'b1;
    e.v.st  = 3'd2;
    push(1, e);
    e.v.st = 3'd3;
    push(1, e);
    repeat (4) @(posedge clk);
    #2;
    check("pre_reset_in_mem", 16'(st[1]), 16'd3);
    rs[1] = 1'b1;
    #1;
    check("async_reset_state", 16'(st[1]), 16'd0);
    check("async_reset_enables", 16'({pcwr[1], irwr[1], rw[1], mr[1], mw[1], dn[1]}), 16'h0);
    repeat (2) @(posedge clk);
    #1;
    check("held_reset_enables", 16'({st[1], pcwr[1], irwr[1], mw[1], dn[1]}), 16'h0);
    rs[1] = 1'b0;
    issue(1, 6'h00, 6'h21, 1'b0, K_ALU, 4, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    check("scoreboard_drained", 16'(q.size()), 16'd0);
    check("writes_d0", 16'(wcnt[0]), 16'd1);
    check("writes_d1", 16'(wcnt[1]), 16'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter MEM_WAIT, default 0: number of extra stall cycles spent in MEM before the memory access completes (0..15).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op  input  6  opcode field (IR[31:26]) of the held instruction.
REQ-005 funct  input  6  function field (IR[5:0]) of the held instruction.
REQ-006 zero  input  1  ALU equality flag, valid in EXE.
REQ-007 PCWr / IRWr  output  1 each  PC-register and instruction-register write enables.
REQ-008 PC_sel  output  2  next-PC source: 00 PC+4, 01 branch target, 10 jump target, 11 rs.
REQ-009 RegDst  output  2  write register: 00 rt, 01 rd, 10 $31.
REQ-010 Data_to_Reg_sel  output  2  write data: 00 ALU, 01 DM, 10 PC.
REQ-011 ALUSrc, ExtOp, RegWrite, MemRead, MemWrite  output  1 each  ALU B = immediate, sign-extend, GPR write, DM read, DM write.
REQ-012 ALUCtr  output  5  ALU operation: 0 add, 1 sub, 2 or, 3 lui.
REQ-013 state  output  3  current state: FETCH 0, DECODE 1, EXE 2, MEM 3, WB 4.
REQ-014 done  output  1  one-cycle pulse in the last cycle of every instruction.

Function
REQ-015 Supported instructions: addu (0/21h), subu (0/23h), jr (0/08h), ori 0Dh, lui 0Fh, lw 23h, sw 2Bh, beq 04h, j 02h, jal 03h; any other op/funct is undefined.
REQ-016 FETCH: IRWr=1, PCWr=1, PC_sel=00; next DECODE.
REQ-017 DECODE: j -> PCWr=1, PC_sel=10, done=1, next FETCH.
REQ-018 DECODE: jal -> PCWr=1, PC_sel=10, RegWrite=1, RegDst=10, Data_to_Reg_sel=10 (PC already holds PC+4), done=1, next FETCH.
REQ-019 DECODE: jr -> PCWr=1, PC_sel=11, done=1, next FETCH.
REQ-020 DECODE: undefined instruction -> no enable asserted, done=1, next FETCH (executes as nop).
REQ-021 DECODE: all other instructions -> next EXE.
REQ-022 EXE: ALUCtr per op (addu/lw/sw add, subu/beq sub, ori or, lui lui); ALUSrc=1 and ExtOp=1 for lw/sw; ALUSrc=1, ExtOp=0 for ori/lui.
REQ-023 EXE beq: PCWr=zero (combinational, same cycle), PC_sel=01, done=1, next FETCH.
REQ-024 EXE: lw/sw -> MEM; addu/subu/ori/lui -> WB.
REQ-025 MEM: 4-bit wait counter loaded to 0 on entry, increments each MEM cycle; MEM lasts MEM_WAIT+1 cycles.
REQ-026 MEM lw: MemRead=1 for every MEM cycle; on final cycle next WB.
REQ-027 MEM sw: MemWrite=1 only in final MEM cycle (exactly one write per sw); done=1 in that cycle; next FETCH.
REQ-028 WB: RegWrite=1; RegDst=01 for R-type, 00 otherwise; Data_to_Reg_sel=01 for lw, 00 otherwise; done=1; next FETCH.
REQ-029 Datapath selects (RegDst, ALUSrc, ExtOp, ALUCtr, Data_to_Reg_sel) hold their decoded value through EXE, MEM and WB of an instruction; write enables are asserted only in the states listed above.
REQ-030 Unused state encodings (5-7) return to FETCH on the next edge with all enables 0.
REQ-031 CPI: j/jr/jal/undefined 2; beq 3; R-type/ori/lui 4; sw 4+MEM_WAIT; lw 5+MEM_WAIT.

Reset
REQ-032 reset high immediately forces state=FETCH, wait counter=0 and PCWr, IRWr, RegWrite, MemRead, MemWrite, done to 0 without waiting for clk.
REQ-033 Reset asserted mid-instruction (any state, including mid-MEM) abandons that instruction; no write enable is asserted until the first FETCH after reset deasserts.
REQ-034 The first rising edge after reset deasserts executes FETCH.

Verification
REQ-035 Reset, then op=23h (lw), MEM_WAIT=0 -> states 0,1,2,3,4,0; MemRead high in state 3; RegWrite and Data_to_Reg_sel=01 in state 4; done pulses once.
REQ-036 op=04h, zero=1 then zero=0 -> 3-cycle instruction; PCWr=1, PC_sel=01 in EXE only when zero=1.
REQ-037 op=03h (jal) -> 2 cycles; in DECODE PCWr=1, PC_sel=10, RegWrite=1, RegDst=10, Data_to_Reg_sel=10.
REQ-038 MEM_WAIT=3, op=2Bh (sw) -> MEM lasts 4 cycles; MemWrite high only in 4th; total 7 cycles.
REQ-039 reset pulse asynchronous to clk while in MEM -> state=0 and MemWrite=0 within the pulse, before the next edge; no write occurs.
REQ-040 op=3Fh (undefined) -> FETCH, DECODE, FETCH; RegWrite, MemWrite and the DECODE-cycle PCWr stay 0.
